memresp: RTL and testbench



---
 rtl/memresp.sv | 165 ++++++++++++++++
 tb/tb_memresp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/memresp.sv
// memresp: memory-side responder for the cache controller's external bus.
// Accepts single-word read/write requests, waits a fixed number of cycles,
// performs the access on an internal word RAM with byte-enable merge and
// reports completion with a one-cycle memdone pulse.
module memresp #(
  parameter int unsigned ADRBITS  = 11,
  parameter int unsigned READLAT  = 3,
  parameter int unsigned WRITELAT = 2
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [26:0] memadr,
  input  logic [31:0] memdatain,
  output logic [31:0] memdataout,
  output logic        memdataoe,
  input  logic [3:0]  membyteen,
  input  logic        memrwb,
  input  logic        memen,
  output logic        memdone
);

  localparam int unsigned MAXLAT = (READLAT > WRITELAT) ? READLAT : WRITELAT;
  localparam int unsigned CNTW   = (MAXLAT < 2) ? 1 : $clog2(MAXLAT + 1);
  localparam int unsigned WORDS  = 1 << ADRBITS;
  localparam logic [CNTW-1:0] RLOAD = CNTW'(READLAT - 1);
  localparam logic [CNTW-1:0] WLOAD = CNTW'(WRITELAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNTW-1:0]     cnt;
  logic [CNTW-1:0]     cnt_nxt;
  logic [CNTW-1:0]     load;

  logic [ADRBITS-1:0]  adr_q;
  logic [31:0]         data_q;
  logic [3:0]          be_q;
  logic                rwb_q;

  logic [ADRBITS-1:0]  acc_adr;
  logic [31:0]         acc_data;
  logic [3:0]          acc_be;
  logic                acc_rwb;

  logic                do_access;
  logic                done_nxt;
  logic                oe_nxt;

  logic [31:0]         ram [WORDS];

  // Upper address bits alias onto the RAM and are intentionally dropped.
  logic                unused_adr;
  assign unused_adr = ^memadr;

  // A zero-wait access happens on the acceptance edge, before the latches
  // are loaded, so it must see the live bus; otherwise use the latched copy.
  assign acc_adr  = (state == IDLE) ? memadr[ADRBITS-1:0] : adr_q;
  assign acc_data = (state == IDLE) ? memdatain : data_q;
  assign acc_be   = (state == IDLE) ? membyteen : be_q;
  assign acc_rwb  = (state == IDLE) ? memrwb : rwb_q;

  // State and wait-counter register.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = memrwb ? RLOAD : WLOAD;
    case (state)
      IDLE: begin
        if (memen) begin
          cnt_nxt   = load;
          state_nxt = (load == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (!memen) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = memen ? HOLD : IDLE;
      end
      HOLD: begin
        if (!memen) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: the access fires on exactly the edge that enters DONE.
  always_comb begin
    do_access = 1'b0;
    done_nxt  = 1'b0;
    oe_nxt    = 1'b0;
    if (state_nxt == DONE) begin
      do_access = 1'b1;
      done_nxt  = 1'b1;
      oe_nxt    = acc_rwb;
    end
  end

  // Request capture on acceptance; later bus changes are ignored.
  always_ff @(posedge ph1) begin
    if (state == IDLE && memen) begin
      adr_q  <= memadr[ADRBITS-1:0];
      data_q <= memdatain;
      be_q   <= membyteen;
      rwb_q  <= memrwb;
    end
  end

  // Registered bus outputs and read data.
  always_ff @(posedge ph1) begin
    if (reset) begin
      memdone    <= 1'b0;
      memdataoe  <= 1'b0;
      memdataout <= '0;
    end else begin
      memdone   <= done_nxt;
      memdataoe <= oe_nxt;
      if (do_access && acc_rwb) begin
        memdataout <= ram[acc_adr];
      end
    end
  end

  // RAM write with per-byte merge; contents are not reset.
  always_ff @(posedge ph1) begin
    if (!reset && do_access && !acc_rwb) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          ram[acc_adr][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_memresp.sv
// Bench for memresp: table-driven vectors, hand-written corner sequences and
// randomized transactions against a word-level memory model.
module tb_memresp;

  localparam int RL  = 3;
  localparam int WL  = 2;
  localparam int RL1 = 1;

  logic        ph1;
  logic        reset;
  logic [26:0] memadr;
  logic [31:0] memdatain;
  logic [3:0]  membyteen;
  logic        memrwb;
  logic        memen;

  logic [31:0] dout0, dout1;
  logic        oe0, oe1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [2048];
  logic [31:0] last_rd0;

  memresp #(.ADRBITS(11), .READLAT(RL), .WRITELAT(WL)) u_main (
    .ph1(ph1), .reset(reset), .memadr(memadr), .memdatain(memdatain),
    .memdataout(dout0), .memdataoe(oe0), .membyteen(membyteen),
    .memrwb(memrwb), .memen(memen), .memdone(done0)
  );

  memresp #(.ADRBITS(11), .READLAT(RL1), .WRITELAT(WL)) u_lat1 (
    .ph1(ph1), .reset(reset), .memadr(memadr), .memdatain(memdatain),
    .memdataout(dout1), .memdataoe(oe1), .membyteen(membyteen),
    .memrwb(memrwb), .memen(memen), .memdone(done1)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  typedef struct {
    bit          rwb;
    logic [26:0] adr;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // One complete bus transaction observed on instance sel, then memen low for one edge.
  task automatic xact(input bit sel, input bit rwb, input logic [26:0] adr,
                      input logic [31:0] d, input logic [3:0] be, input string nm);
    int edges;
    int lat;
    int idx;
    bit got;
    idx = int'(adr[10:0]);
    lat = rwb ? (sel ? RL1 : RL) : WL;
    memen = 1'b1; memrwb = rwb; memadr = adr; memdatain = d; membyteen = be;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 20) begin
      tick();
      edges++;
      if (sel ? done1 : done0) got = 1'b1;
      else if (edges == 1) begin
        memadr    = 27'($urandom());
        memdatain = $urandom();
        membyteen = 4'($urandom());
        memrwb    = 1'($urandom());
      end
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_latency"}, 32'(edges), 32'(lat));
      chk({nm, "_oe"}, 32'(sel ? oe1 : oe0), 32'(rwb));
      if (rwb) begin
        chk({nm, "_rdata"}, sel ? dout1 : dout0, mdl[idx]);
        if (!sel) last_rd0 = mdl[idx];
      end else begin
        if (!sel) chk({nm, "_dout_hold"}, dout0, last_rd0);
        mdl[idx] = merge(mdl[idx], d, be);
      end
    end
    memen = 1'b0;
    tick();
    chk({nm, "_done_low"}, 32'(sel ? done1 : done0), 32'd0);
    chk({nm, "_oe_low"}, 32'(sel ? oe1 : oe0), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int edges;
    int pulses;
    bit got;
    int idx;

    vecs[0] = '{1'b0, 27'h0000010, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{1'b1, 27'h0000010, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 27'h0000020, 32'h11223344, 4'hF, 32'h0};
    vecs[3] = '{1'b0, 27'h0000020, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4] = '{1'b1, 27'h0000020, 32'h0,        4'hF, 32'h11BB33DD};
    vecs[5] = '{1'b0, 27'h0000020, 32'h00000000, 4'h0, 32'h0};
    vecs[6] = '{1'b1, 27'h0000020, 32'h0,        4'hF, 32'h11BB33DD};
    vecs[7] = '{1'b0, 27'h4000030, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[8] = '{1'b1, 27'h0000030, 32'h0,        4'hF, 32'hCAFEF00D};

    for (int i = 0; i < 2048; i++) mdl[i] = 32'h0;
    last_rd0 = 32'h0;

    reset = 1'b1; memen = 1'b0; memrwb = 1'b1; memadr = '0;
    memdatain = '0; membyteen = '0;
    repeat (3) tick();
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_dout", dout0, 32'h0);
    chk("rst_done_lat1", 32'(done1), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven write/read/merge/alias vectors.
    for (int i = 0; i < 9; i++) begin
      xact(1'b0, vecs[i].rwb, vecs[i].adr, vecs[i].d, vecs[i].be, $sformatf("vec%0d", i));
      if (vecs[i].rwb) chk($sformatf("vec%0d_table", i), dout0, vecs[i].exp);
    end

    // Reset in the middle of a write: no RAM update, outputs cleared.
    xact(1'b0, 1'b0, 27'd5, 32'h5A5A0005, 4'hF, "pre_w5");
    memen = 1'b1; memrwb = 1'b0; memadr = 27'd5; memdatain = 32'hFFFFFFFF; membyteen = 4'hF;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("midrst%0d_done", k), 32'(done0), 32'd0);
      chk($sformatf("midrst%0d_oe", k), 32'(oe0), 32'd0);
      chk($sformatf("midrst%0d_dout", k), dout0, 32'h0);
    end
    reset = 1'b0; memen = 1'b0;
    tick();
    chk("postrst_done", 32'(done0), 32'd0);
    last_rd0 = 32'h0;
    xact(1'b0, 1'b1, 27'd5, 32'h0, 4'hF, "rd5_after_rst");

    // Abort a read after one busy edge: no completion, read data unchanged.
    memen = 1'b1; memrwb = 1'b1; memadr = 27'h10; membyteen = 4'hF;
    tick();
    tick();
    memen = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done0) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_dout", dout0, last_rd0);
    xact(1'b0, 1'b1, 27'h20, 32'h0, 4'hF, "after_abort");

    // memen held after completion: one pulse, no re-execution.
    memen = 1'b1; memrwb = 1'b0; memadr = 27'h40; memdatain = 32'h600DF00D; membyteen = 4'hF;
    edges = 0; got = 1'b0;
    while (!got && edges < 20) begin
      tick();
      edges++;
      if (done0) got = 1'b1;
    end
    chk("held_latency", 32'(edges), 32'(WL));
    mdl[32'h40] = 32'h600DF00D;
    memdatain = 32'hBAD0BAD0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done0 || oe0) pulses++;
    end
    chk("held_single_pulse", 32'(pulses), 32'd0);
    memen = 1'b0;
    tick();
    xact(1'b0, 1'b1, 27'h40, 32'h0, 4'hF, "held_readback");

    // Zero-wait read on the READLAT=1 instance with upper-address aliasing.
    xact(1'b1, 1'b0, 27'h0000010, 32'hC0FFEE10, 4'hF, "lat1_w");
    xact(1'b1, 1'b1, 27'h0000810, 32'h0, 4'hF, "lat1_alias_r");

    // Randomized traffic over a small initialized window.
    for (int i = 0; i < 16; i++)
      xact(1'b0, 1'b0, {16'($urandom()), 11'(i)}, $urandom(), 4'hF, $sformatf("init%0d", i));
    for (int i = 0; i < 60; i++) begin
      idx = int'($urandom_range(0, 15));
      xact(1'b0, 1'($urandom()), {16'($urandom()), 11'(idx)}, $urandom(), 4'($urandom()),
           $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
